s3g_tx_arb: RTL and testbench
=============================

S3G_TX_ARB -- requirements
Module: s3g_tx_arb

Interface
REQ-001 Parameter: BUSY_TIMEOUT, 4, cycles WAIT_BUSY waits for tx_busy before abort; legal 2..15.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0, req1, req2  input  1 each  level packet request; held until matching ack.
REQ-005 len0, len1, len2  input  4 each  payload byte count; values 9..15 saturate to 8.
REQ-006 data0, data1, data2  input  64 each  payload; byte i = bits [8i+7:8i].
REQ-007 tx_busy  input  1  busy output of downstream S3G packet transmitter.
REQ-008 packet_wr  output  1  one-cycle packet strobe to transmitter.
REQ-009 payload_len  output  8  latched length, upper 4 bits always 0.
REQ-010 pkt_buf  output  64  latched payload, byte i drives transmitter buf_i; buf8..15 tied 0 by integrator.
REQ-011 ack0, ack1, ack2  output  1 each  one-cycle grant pulse, coincident with packet_wr.
REQ-012 grant  output  2  index of last granted requester.
REQ-013 active  output  1  high in every state except S_IDLE.
REQ-014 err_timeout  output  1  sticky, set on busy-wait timeout.
REQ-015 pkt_count  output  16  count of issued packets, wraps 0xFFFF->0.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States: S_IDLE, S_WRITE, S_WAIT_BUSY, S_WAIT_DONE; illegal encoding -> S_IDLE next cycle.
REQ-018 S_IDLE: if any req high and tx_busy low, select winner, load payload_len/pkt_buf from winner, set packet_wr=1, ack<winner>=1, grant=winner, pkt_count+=1, go S_WRITE.
REQ-019 S_IDLE with tx_busy high: no grant regardless of req; stay.
REQ-020 Arbitration SHALL be round-robin: search order starts at grant+1 mod 3, wraps; first high req wins.
REQ-021 Request-to-packet_wr latency SHALL be 1 cycle (req sampled in S_IDLE cycle t, packet_wr high in t+1).
REQ-022 S_WRITE: packet_wr and ack high exactly this cycle; next state S_WAIT_BUSY, clear timeout counter.
REQ-023 S_WAIT_BUSY: tx_busy high -> S_WAIT_DONE; else increment counter; on counter reaching BUSY_TIMEOUT -> set err_timeout, go S_IDLE.
REQ-024 S_WAIT_DONE: tx_busy low -> S_IDLE; no grant in this cycle.
REQ-025 payload_len and pkt_buf SHALL hold stable from packet_wr until next grant.
REQ-026 Length saturation: lenN>8 -> payload_len=8; lenN=0 is legal and passes as 0.
REQ-027 Requester dropping req before grant SHALL get no ack; req still high after ack in next S_IDLE is a new request.
REQ-028 Only one ack SHALL be high in any cycle.
REQ-029 err_timeout SHALL clear only on rst.

Reset
REQ-030 On rst: state S_IDLE, packet_wr=0, payload_len=0, pkt_buf=0, ack0..2=0, grant=2, active=0, err_timeout=0, pkt_count=0, timeout counter=0.
REQ-031 rst asserted in any state, including mid-packet, SHALL take effect next edge with no packet_wr/ack emitted; first grant after rst goes to req0 when all requests are high.

Verification
REQ-032 After rst, req0=req1=req2=1, tx_busy=0, len1=3 -> packet_wr in cycle 2, ack0, grant=0; then ack1, then ack2, in that order, with a busy pulse after each.
REQ-033 req2=1, len2=12, data2=0x8877665544332211 -> payload_len=0x08, pkt_buf=0x8877665544332211, pkt_count=1.
REQ-034 tx_busy held 0 after packet_wr, BUSY_TIMEOUT=4 -> err_timeout=1 after 4 cycles in S_WAIT_BUSY, return to S_IDLE, active=0.
REQ-035 req1=1 while tx_busy=1 in S_IDLE -> no ack until tx_busy=0, then ack1 next cycle.
REQ-036 rst asserted in S_WAIT_DONE -> active=0 and grant=2 next cycle, no ack; pkt_count after 65536 grants returns to 0.

Source files
------------

// File: rtl/s3g_tx_arb_if.sv
// Bundle of the requester-side and transmitter-side signals of the S3G TX arbiter.
// The master side (requesters plus the transmitter's busy flag) drives the
// requests and tx_busy. The slave side (the arbiter) drives the packet strobe,
// the latched payload, the grants and the status outputs.
interface s3g_tx_arb_if;
  // requester side
  logic        req0;
  logic        req1;
  logic        req2;
  logic [3:0]  len0;
  logic [3:0]  len1;
  logic [3:0]  len2;
  logic [63:0] data0;
  logic [63:0] data1;
  logic [63:0] data2;
  // downstream transmitter status
  logic        tx_busy;
  // arbiter outputs
  logic        packet_wr;
  logic [7:0]  payload_len;
  logic [63:0] pkt_buf;
  logic        ack0;
  logic        ack1;
  logic        ack2;
  logic [1:0]  grant;
  logic        active;
  logic        err_timeout;
  logic [15:0] pkt_count;

  modport master (
    output req0, req1, req2,
    output len0, len1, len2,
    output data0, data1, data2,
    output tx_busy,
    input  packet_wr, payload_len, pkt_buf,
    input  ack0, ack1, ack2,
    input  grant, active, err_timeout, pkt_count
  );

  modport slave (
    input  req0, req1, req2,
    input  len0, len1, len2,
    input  data0, data1, data2,
    input  tx_busy,
    output packet_wr, payload_len, pkt_buf,
    output ack0, ack1, ack2,
    output grant, active, err_timeout, pkt_count
  );
endinterface

// File: rtl/s3g_tx_arb.sv
// Three-way round-robin arbiter in front of an S3G packet transmitter.
// A winner's length and payload are latched together with a one-cycle
// packet_wr/ack pulse. The FSM then waits for the transmitter to raise tx_busy
// (with a timeout) and then to drop it again before the next grant.
// Every output is driven straight from a register.
module s3g_tx_arb #(
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  s3g_tx_arb_if.slave   bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  // The counter reaches BUSY_TIMEOUT on the cycle the timeout is declared.
  // Comparing against the value one below that lets the abort happen on that
  // same edge.
  localparam logic [3:0] TOUT_LAST = 4'(BUSY_TIMEOUT - 1);

  logic [1:0]  state_reg;
  logic        packet_wr_reg;
  logic [7:0]  payload_len_reg;
  logic [63:0] pkt_buf_reg;
  logic [2:0]  ack_reg;
  logic [1:0]  grant_reg;
  logic        active_reg;
  logic        err_timeout_reg;
  logic [15:0] pkt_count_reg;
  logic [3:0]  tout_cnt_reg;

  logic [2:0]  req_vec;
  logic [3:0]  len_raw [3];
  logic [3:0]  len_sat [3];
  logic [63:0] data_arr [3];

  logic [1:0]  rr_start;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [2:0]  cand;

  // Collect the per-requester scalars into indexable arrays.
  assign req_vec     = {bus.req2, bus.req1, bus.req0};
  assign len_raw[0]  = bus.len0;
  assign len_raw[1]  = bus.len1;
  assign len_raw[2]  = bus.len2;
  assign data_arr[0] = bus.data0;
  assign data_arr[1] = bus.data1;
  assign data_arr[2] = bus.data2;

  // The payload holds at most 8 bytes, so longer lengths are clipped to 8.
  // A length of 0 passes through unchanged.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_len_sat
      assign len_sat[gi] = (len_raw[gi] > 4'd8) ? 4'd8 : len_raw[gi];
    end
  endgenerate

  // Start the search one past the last winner. A grant value of 2 (the reset
  // value) wraps to 0, so after reset requester 0 has first priority.
  always_comb begin
    rr_start = (grant_reg >= 2'd2) ? 2'd0 : grant_reg + 2'd1;
  end

  // The search runs from the farthest candidate back to the nearest, so the
  // nearest high request is the last one written and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, rr_start} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (req_vec[cand[1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  // Main FSM and output registers.
  // packet_wr and ack fall back to 0 every cycle unless a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      packet_wr_reg   <= 1'b0;
      payload_len_reg <= 8'd0;
      pkt_buf_reg     <= 64'd0;
      ack_reg         <= 3'b000;
      grant_reg       <= 2'd2;
      active_reg      <= 1'b0;
      err_timeout_reg <= 1'b0;
      pkt_count_reg   <= 16'd0;
      tout_cnt_reg    <= 4'd0;
    end else begin
      packet_wr_reg <= 1'b0;
      ack_reg       <= 3'b000;
      case (state_reg)
        S_IDLE: begin
          // A busy transmitter blocks every grant, whatever the requests are.
          if (win_valid && !bus.tx_busy) begin
            state_reg       <= S_WRITE;
            packet_wr_reg   <= 1'b1;
            ack_reg         <= 3'b001 << win_idx;
            grant_reg       <= win_idx;
            payload_len_reg <= {4'b0000, len_sat[win_idx]};
            pkt_buf_reg     <= data_arr[win_idx];
            pkt_count_reg   <= pkt_count_reg + 16'd1;
            active_reg      <= 1'b1;
          end else begin
            active_reg <= 1'b0;
          end
        end
        S_WRITE: begin
          // The strobe is visible during this state. Arm the busy-wait timer.
          state_reg    <= S_WAIT_BUSY;
          tout_cnt_reg <= 4'd0;
          active_reg   <= 1'b1;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_reg  <= S_WAIT_DONE;
            active_reg <= 1'b1;
          end else if (tout_cnt_reg == TOUT_LAST) begin
            // The transmitter never acknowledged the packet. Flag it and give up.
            tout_cnt_reg    <= tout_cnt_reg + 4'd1;
            err_timeout_reg <= 1'b1;
            state_reg       <= S_IDLE;
            active_reg      <= 1'b0;
          end else begin
            tout_cnt_reg <= tout_cnt_reg + 4'd1;
            active_reg   <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_reg  <= S_IDLE;
            active_reg <= 1'b0;
          end else begin
            active_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  // Drive the interface outputs from the registers.
  assign bus.packet_wr   = packet_wr_reg;
  assign bus.payload_len = payload_len_reg;
  assign bus.pkt_buf     = pkt_buf_reg;
  assign bus.ack0        = ack_reg[0];
  assign bus.ack1        = ack_reg[1];
  assign bus.ack2        = ack_reg[2];
  assign bus.grant       = grant_reg;
  assign bus.active      = active_reg;
  assign bus.err_timeout = err_timeout_reg;
  assign bus.pkt_count   = pkt_count_reg;

endmodule

// File: tb/tb_s3g_tx_arb.sv
// Scoreboard bench for s3g_tx_arb.
// The stimulus process pushes the expected grant before it raises a request.
// The monitor pops one entry for every packet_wr it sees and compares it.
// A small transmitter model pulses tx_busy after each packet.
module tb_s3g_tx_arb;
  logic clk;
  logic rst;

  s3g_tx_arb_if bus ();

  s3g_tx_arb #(.BUSY_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [7:0]  len;
    logic [63:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic busy_force;
  logic busy_pulse;
  logic busy_model_en;
  int   busy_len;
  int   busy_left;

  localparam logic [63:0] D0 = 64'h0102030405060708;
  localparam logic [63:0] D1 = 64'hA1A2A3A4A5A6A7A8;
  localparam logic [63:0] D2 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D3 = 64'h8877665544332211;

  assign bus.tx_busy = busy_force | busy_pulse;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] idx, input logic [7:0] len,
                              input logic [63:0] data, input logic [15:0] cnt);
    exp_t e;
    e.idx  = idx;
    e.len  = len;
    e.data = data;
    e.cnt  = cnt;
    return e;
  endfunction

  // Wait for the next packet_wr. Any requester that sees its ack drops its request.
  task automatic wait_pkt(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (bus.ack2) bus.req2 = 1'b0;
      if (bus.packet_wr) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_pkt: no packet_wr within %0d cycles", cyc);
    end
  endtask

  // Transmitter model. It raises busy for busy_len cycles after each packet_wr.
  initial begin
    busy_pulse = 1'b0;
    busy_left  = 0;
    forever begin
      @(negedge clk);
      if (busy_model_en && bus.packet_wr && !rst) begin
        busy_pulse = 1'b1;
        busy_left  = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) busy_pulse = 1'b0;
      end
    end
  end

  // Monitor. It compares every packet and tracks that the latched payload holds between grants.
  initial begin
    exp_t        e;
    logic [7:0]  last_len;
    logic [63:0] last_buf;
    last_len = 8'd0;
    last_buf = 64'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_len = 8'd0;
        last_buf = 64'd0;
      end else if (bus.packet_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt: grant %0d with empty scoreboard", bus.grant);
        end else begin
          e = exp_q.pop_front();
          chk("ack_vec", {61'd0, bus.ack2, bus.ack1, bus.ack0}, 64'd1 << e.idx);
          chk("grant", {62'd0, bus.grant}, {62'd0, e.idx});
          chk("payload_len", {56'd0, bus.payload_len}, {56'd0, e.len});
          chk("pkt_buf", bus.pkt_buf, e.data);
          chk("pkt_count", {48'd0, bus.pkt_count}, {48'd0, e.cnt});
        end
        last_len = bus.payload_len;
        last_buf = bus.pkt_buf;
      end else begin
        chk("no_ack_without_wr", {61'd0, bus.ack2, bus.ack1, bus.ack0}, 64'd0);
        chk("len_hold", {56'd0, bus.payload_len}, {56'd0, last_len});
        chk("buf_hold", bus.pkt_buf, last_buf);
      end
    end
  end

  // Directed stimulus.
  initial begin
    int cyc;
    rst           = 1'b1;
    busy_force    = 1'b0;
    busy_model_en = 1'b1;
    busy_len      = 2;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.req2 = 1'b0;
    bus.len0 = 4'd5; bus.len1 = 4'd3; bus.len2 = 4'd15;
    bus.data0 = D0;  bus.data1 = D1;  bus.data2 = D2;
    repeat (3) @(negedge clk);

    // Check the reset values.
    chk("rst_packet_wr", {63'd0, bus.packet_wr}, 64'd0);
    chk("rst_payload_len", {56'd0, bus.payload_len}, 64'd0);
    chk("rst_pkt_buf", bus.pkt_buf, 64'd0);
    chk("rst_acks", {61'd0, bus.ack2, bus.ack1, bus.ack0}, 64'd0);
    chk("rst_grant", {62'd0, bus.grant}, 64'd2);
    chk("rst_active", {63'd0, bus.active}, 64'd0);
    chk("rst_err", {63'd0, bus.err_timeout}, 64'd0);
    chk("rst_count", {48'd0, bus.pkt_count}, 64'd0);
    rst = 1'b0;

    // All three requesters high: the grants go 0, 1, 2 in order, with a busy pulse after each.
    exp_q.push_back(mk(2'd0, 8'd5, D0, 16'd1));
    exp_q.push_back(mk(2'd1, 8'd3, D1, 16'd2));
    exp_q.push_back(mk(2'd2, 8'd8, D2, 16'd3));
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.req2 = 1'b1;
    wait_pkt(cyc);
    chk("req_to_wr_latency", 64'(cyc), 64'd1);
    wait_pkt(cyc);
    wait_pkt(cyc);
    repeat (6) @(negedge clk);

    // A single request with length 12 saturates to 8 and passes the full payload.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.len2  = 4'd12;
    bus.data2 = D3;
    exp_q.push_back(mk(2'd2, 8'h08, D3, 16'd1));
    bus.req2 = 1'b1;
    wait_pkt(cyc);
    repeat (6) @(negedge clk);

    // The transmitter never goes busy: the timeout fires after 4 cycles in S_WAIT_BUSY.
    // A length of 0 passes as 0.
    busy_model_en = 1'b0;
    bus.len0 = 4'd0;
    exp_q.push_back(mk(2'd0, 8'd0, D0, 16'd2));
    bus.req0 = 1'b1;
    wait_pkt(cyc);
    repeat (4) @(negedge clk);
    chk("tout_err_before", {63'd0, bus.err_timeout}, 64'd0);
    chk("tout_active_before", {63'd0, bus.active}, 64'd1);
    @(negedge clk);
    chk("tout_err_set", {63'd0, bus.err_timeout}, 64'd1);
    chk("tout_active_idle", {63'd0, bus.active}, 64'd0);
    busy_model_en = 1'b1;
    repeat (2) @(negedge clk);

    // While tx_busy is held high in S_IDLE there is no grant. After busy drops, ack1 comes one cycle later.
    busy_force = 1'b1;
    bus.len1 = 4'd7;
    bus.req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_block_ack1", {63'd0, bus.ack1}, 64'd0);
      chk("busy_block_active", {63'd0, bus.active}, 64'd0);
    end
    exp_q.push_back(mk(2'd1, 8'd7, D1, 16'd3));
    busy_force = 1'b0;
    @(negedge clk);
    chk("busy_release_ack1", {63'd0, bus.ack1}, 64'd1);
    bus.req1 = 1'b0;
    chk("err_sticky", {63'd0, bus.err_timeout}, 64'd1);
    repeat (8) @(negedge clk);

    // Assert reset while in S_WAIT_DONE. Then the first grant with all requesters high goes to req0.
    busy_len = 3;
    bus.len1 = 4'd2;
    exp_q.push_back(mk(2'd1, 8'd2, D1, 16'd4));
    bus.req1 = 1'b1;
    wait_pkt(cyc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_active", {63'd0, bus.active}, 64'd0);
    chk("rst_mid_grant", {62'd0, bus.grant}, 64'd2);
    chk("rst_mid_acks", {61'd0, bus.ack2, bus.ack1, bus.ack0}, 64'd0);
    chk("rst_mid_wr", {63'd0, bus.packet_wr}, 64'd0);
    chk("rst_mid_err", {63'd0, bus.err_timeout}, 64'd0);
    chk("rst_mid_count", {48'd0, bus.pkt_count}, 64'd0);
    rst = 1'b0;
    exp_q.push_back(mk(2'd0, 8'd0, D0, 16'd1));
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.req2 = 1'b1;
    wait_pkt(cyc);
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.req2 = 1'b0;
    repeat (10) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
